// File: rtl/aes_decrypt_iter.sv
// Iterative AES inverse cipher: one decrypt round per clock on a single
// registered 128-bit state, runtime-selectable AES-128/192/256.
// Optional feature macro: AES_DEC_ABORT_EN adds an 'abort' input that
// discards the in-flight block from RUN or DONE.
module aes_decrypt_iter #(
  parameter int unsigned MAX_NR = 14,
  parameter int unsigned TAG_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inValid,
  output logic              inReady,
  input  logic [127:0]      inData,
  input  logic [TAG_W-1:0]  inTag,
  input  logic [1:0]        keyLen,
  output logic [3:0]        roundKeyIdx,
  input  logic [127:0]      roundKey,
  output logic              outValid,
  input  logic              outReady,
  output logic [127:0]      outData,
`ifdef AES_DEC_ABORT_EN
  input  logic              abort,
`endif
  output logic [TAG_W-1:0]  outTag
);

  localparam int unsigned RW = $clog2(MAX_NR);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  logic [1:0]       r_fsm;
  logic [RW-1:0]    r_round;
  logic [3:0]       r_nr;
  logic [127:0]     r_state;
  logic [TAG_W-1:0] r_tag;

  logic [3:0]       w_nr_dec;
  logic [3:0]       w_rk_idx;
  logic [127:0]     w_ark;
  logic [127:0]     w_imc;
  logic             w_abort;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+4-r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned i = 0; i < 16; i++)
      o[127-8*i -: 8] = INV_SBOX[2047-8*32'(s[127-8*i -: 8]) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a [4];
    logic [7:0]   m2 [4];
    logic [7:0]   m4 [4];
    logic [7:0]   m8 [4];
    logic [7:0]   m9 [4];
    logic [7:0]   mb [4];
    logic [7:0]   md [4];
    logic [7:0]   me [4];
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        a[r]  = s[127-8*(r+4*c) -: 8];
        m2[r] = xt(a[r]);
        m4[r] = xt(m2[r]);
        m8[r] = xt(m4[r]);
        m9[r] = m8[r] ^ a[r];
        mb[r] = m8[r] ^ m2[r] ^ a[r];
        md[r] = m8[r] ^ m4[r] ^ a[r];
        me[r] = m8[r] ^ m4[r] ^ m2[r];
      end
      o[127-8*(4*c)   -: 8] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
      o[127-8*(4*c+1) -: 8] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
      o[127-8*(4*c+2) -: 8] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
      o[127-8*(4*c+3) -: 8] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
    end
    return o;
  endfunction

`ifdef AES_DEC_ABORT_EN
  assign w_abort = abort && (r_fsm != S_IDLE);
`else
  assign w_abort = 1'b0;
`endif

  // Round count from keyLen; reserved code and anything above MAX_NR fall back to 10
  always_comb begin
    case (keyLen)
      2'd1:    w_nr_dec = 4'd12;
      2'd2:    w_nr_dec = 4'd14;
      default: w_nr_dec = 4'd10;
    endcase
    if ({28'd0, w_nr_dec} > MAX_NR) w_nr_dec = 4'd10;
  end

  // Round-key index depends only on FSM state, round counter and keyLen
  always_comb begin
    w_rk_idx = '0;
    case (r_fsm)
      S_IDLE:  w_rk_idx = w_nr_dec;
      S_RUN:   w_rk_idx = (4'(r_round) > r_nr) ? r_nr : 4'(r_round);
      default: w_rk_idx = '0;
    endcase
  end

  // One inverse round: InvShiftRows -> InvSubBytes -> AddRoundKey [-> InvMixColumns]
  always_comb begin
    w_ark = inv_sub_bytes(inv_shift_rows(r_state)) ^ roundKey;
    w_imc = inv_mix_columns(w_ark);
  end

  // Control FSM, round counter and the shared state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm   <= S_IDLE;
      r_round <= '0;
      r_nr    <= 4'd10;
      r_state <= '0;
      r_tag   <= '0;
    end else if (w_abort) begin
      r_fsm   <= S_IDLE;
      r_state <= '0;
      r_tag   <= '0;
    end else begin
      case (r_fsm)
        S_IDLE: if (inValid) begin
          r_state <= inData ^ roundKey;
          r_tag   <= inTag;
          r_nr    <= w_nr_dec;
          r_round <= RW'(w_nr_dec - 4'd1);
          r_fsm   <= S_RUN;
        end
        S_RUN: if (r_round == '0) begin
          r_state <= w_ark;
          r_fsm   <= S_DONE;
        end else begin
          r_state <= w_imc;
          r_round <= r_round - 1'b1;
        end
        S_DONE: if (outReady) r_fsm <= S_IDLE;
        default: r_fsm <= S_IDLE;
      endcase
    end
  end

  assign inReady     = (r_fsm == S_IDLE) && rst_n;
  assign outValid    = (r_fsm == S_DONE);
  assign outData     = r_state;
  assign outTag      = r_tag;
  assign roundKeyIdx = w_rk_idx;

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Bench for aes_decrypt_iter: FIPS-197 vectors plus random blocks encrypted by
// a forward-cipher model; round-key ROM built by a local key expansion.
module tb_aes_decrypt_iter;
  localparam int TAG_W = 8;

  logic             clk = 0;
  logic             rst_n = 0;
  logic             inValid = 0;
  logic             inReady;
  logic [127:0]     inData = '0;
  logic [TAG_W-1:0] inTag = '0;
  logic [1:0]       keyLen = '0;
  logic [3:0]       roundKeyIdx;
  logic [127:0]     roundKey;
  logic             outValid;
  logic             outReady = 0;
  logic [127:0]     outData;
  logic [TAG_W-1:0] outTag;
`ifdef AES_DEC_ABORT_EN
  logic             abort = 0;
`endif

  aes_decrypt_iter #(.MAX_NR(14), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .inValid(inValid), .inReady(inReady),
    .inData(inData), .inTag(inTag), .keyLen(keyLen),
    .roundKeyIdx(roundKeyIdx), .roundKey(roundKey),
    .outValid(outValid), .outReady(outReady), .outData(outData),
`ifdef AES_DEC_ABORT_EN
    .abort(abort),
`endif
    .outTag(outTag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0;
  int nmis = 0;

  localparam logic [127:0] PT_FIPS = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192   = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256   = 128'h8ea2b7ca516745bfeafc49904b496089;

  typedef struct { logic [127:0] pt; logic [TAG_W-1:0] tag; } exp_t;
  exp_t sb[$];

  logic [7:0]   sbx [256];
  logic [127:0] rks [3][15];
  int           ks_sel = 0;

  assign roundKey = rks[ks_sel][roundKeyIdx];

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 0; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p ^= x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int a = 0; a < 256; a++) begin
      inv = 0;
      for (int b = 1; b < 256; b++)
        if (a != 0 && gm(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
          ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbx[a] = s;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbx[w[31:24]], sbx[w[23:16]], sbx[w[15:8]], sbx[w[7:0]]};
  endfunction

  task automatic expand(input int ks, input logic [255:0] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 15; r++) rks[ks][r] = '0;
    for (int r = 0; r <= nr; r++) rks[ks][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] enc(input logic [127:0] pt, input int ks, input int nr);
    logic [127:0] s, t;
    logic [7:0]   a [4];
    s = pt ^ rks[ks][0];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) s[127-8*i -: 8] = sbx[s[127-8*i -: 8]];
      t = s;
      for (int c = 0; c < 4; c++)
        for (int rw = 0; rw < 4; rw++)
          s[127-8*(rw+4*c) -: 8] = t[127-8*(rw+4*((c+rw)%4)) -: 8];
      if (r != nr) begin
        for (int c = 0; c < 4; c++) begin
          for (int rw = 0; rw < 4; rw++) a[rw] = s[127-8*(rw+4*c) -: 8];
          s[127-8*(4*c)   -: 8] = gm(a[0],2) ^ gm(a[1],3) ^ a[2] ^ a[3];
          s[127-8*(4*c+1) -: 8] = a[0] ^ gm(a[1],2) ^ gm(a[2],3) ^ a[3];
          s[127-8*(4*c+2) -: 8] = a[0] ^ a[1] ^ gm(a[2],2) ^ gm(a[3],3);
          s[127-8*(4*c+3) -: 8] = gm(a[0],3) ^ a[1] ^ a[2] ^ gm(a[3],2);
        end
      end
      s ^= rks[ks][r];
    end
    return s;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one block; returns the cycle-0 sample time of the accept
  task automatic send(input logic [127:0] d, input logic [TAG_W-1:0] t, input logic [1:0] kl,
                      input logic [127:0] pt, output int c, output bit ok);
    exp_t e;
    inData = d; inTag = t; keyLen = kl; inValid = 1; ok = 0; c = 0;
    for (int k = 0; k < 64; k++) begin
      if (inReady) begin
        c = cyc; ok = 1;
        e.pt = pt; e.tag = t;
        sb.push_back(e);
        step();
        break;
      end
      step();
    end
    inValid = 0;
    inData = rnd128(); inTag = ~t; keyLen = ~kl;
  endtask

  // Wait for outValid, capture the block, then complete the handshake
  task automatic recv(output logic [127:0] d, output logic [TAG_W-1:0] t,
                      output int c, output bit ok);
    ok = 0; d = '0; t = '0; c = 0;
    for (int k = 0; k < 64; k++) begin
      if (outValid) begin
        d = outData; t = outTag; c = cyc; ok = 1;
        break;
      end
      step();
    end
    if (ok) begin
      outReady = 1;
      step();
      outReady = 0;
    end
  endtask

  task automatic test_reset();
    rst_n = 0; keyLen = 2'd0;
    #13;
    nvec++; if (outValid !== 1'b0) begin nmis++; $display("FAIL rst_outValid: got %b expected 0", outValid); end
    nvec++; if (inReady !== 1'b0) begin nmis++; $display("FAIL rst_inReady: got %b expected 0", inReady); end
    nvec++; if (outData !== '0) begin nmis++; $display("FAIL rst_outData: got %h expected 0", outData); end
    nvec++; if (outTag !== '0) begin nmis++; $display("FAIL rst_outTag: got %h expected 0", outTag); end
    step();
    rst_n = 1;
    #1;
    nvec++; if (inReady !== 1'b1) begin nmis++; $display("FAIL rel_inReady: got %b expected 1", inReady); end
    nvec++; if (roundKeyIdx !== 4'd10) begin nmis++; $display("FAIL rel_rkidx: got %0d expected 10", roundKeyIdx); end
    step();
  endtask

  task automatic test_aes128();
    int c0;
    bit ok;
    bit seq_ok;
    exp_t e;
    ks_sel = 0; keyLen = 2'd0;
    nvec++; if (roundKeyIdx !== 4'd10) begin nmis++; $display("FAIL c1_idx0: got %0d expected 10", roundKeyIdx); end
    send(CT128, 8'h5A, 2'd0, PT_FIPS, c0, ok);
    nvec++; if (!ok) begin nmis++; $display("FAIL c1_accept: got timeout expected accept"); end
    seq_ok = 1;
    for (int k = 1; k <= 10; k++) begin
      if (roundKeyIdx !== 4'(10 - k) || outValid !== 1'b0) begin
        seq_ok = 0;
        $display("FAIL c1_seq: cycle %0d got idx %0d valid %b expected idx %0d valid 0", k, roundKeyIdx, outValid, 10 - k);
      end
      step();
    end
    nvec++; if (!seq_ok) nmis++;
    nvec++; if (outValid !== 1'b1 || cyc - c0 != 11) begin nmis++; $display("FAIL c1_latency: got valid %b at %0d expected valid 1 at 11", outValid, cyc - c0); end
    e = sb.pop_front();
    nvec++; if (outData !== e.pt) begin nmis++; $display("FAIL c1_data: got %h expected %h", outData, e.pt); end
    nvec++; if (outTag !== e.tag) begin nmis++; $display("FAIL c1_tag: got %h expected %h", outTag, e.tag); end
    nvec++; if (roundKeyIdx !== 4'd0) begin nmis++; $display("FAIL c1_done_idx: got %0d expected 0", roundKeyIdx); end
    outReady = 1;
    step();
    outReady = 0;
    nvec++; if (outValid !== 1'b0 || inReady !== 1'b1) begin nmis++; $display("FAIL c1_release: got valid %b ready %b expected 0 1", outValid, inReady); end
  endtask

  task automatic test_keylens();
    logic [127:0] d, pt;
    logic [TAG_W-1:0] t;
    int c0, c1, nr;
    bit ok;
    exp_t e;
    logic [127:0] cts [3];
    cts[0] = CT192; cts[1] = CT256; cts[2] = CT128;
    for (int i = 0; i < 6; i++) begin
      int kl;
      kl = (i < 3) ? i + 1 : i - 3;
      ks_sel = (kl == 3) ? 0 : kl;
      nr = 10 + 2 * ks_sel;
      pt = (i < 3) ? PT_FIPS : rnd128();
      d  = (i < 3) ? cts[i] : enc(pt, ks_sel, nr);
      send(d, 8'(8'h30 + i), 2'(kl), pt, c0, ok);
      recv(d, t, c1, ok);
      nvec++;
      if (!ok) begin nmis++; $display("FAIL kl%0d_timeout: got no outValid expected block", kl); end
      else begin
        e = sb.pop_front();
        if (d !== e.pt || t !== e.tag || c1 - c0 != nr + 1) begin
          nmis++;
          $display("FAIL kl%0d_block: got %h/%h lat %0d expected %h/%h lat %0d", kl, d, t, c1 - c0, e.pt, e.tag, nr + 1);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] pa, pb, d;
    logic [TAG_W-1:0] t;
    int c0, c1;
    bit ok, stable;
    exp_t e;
    ks_sel = 0;
    pa = rnd128(); pb = rnd128();
    send(enc(pa, 0, 10), 8'h11, 2'd0, pa, c0, ok);
    ok = 0;
    for (int k = 0; k < 64; k++) begin
      if (outValid) begin ok = 1; break; end
      step();
    end
    nvec++; if (!ok) begin nmis++; $display("FAIL bp_valid: got timeout expected outValid"); end
    inData = enc(pb, 0, 10); inTag = 8'h22; keyLen = 2'd0; inValid = 1;
    e = sb[0];
    stable = 1;
    for (int h = 0; h < 20; h++) begin
      if (outValid !== 1'b1 || outData !== e.pt || outTag !== e.tag || inReady !== 1'b0) begin
        stable = 0;
        $display("FAIL bp_hold: cycle %0d got %b %h %h rdy %b expected 1 %h %h rdy 0", h, outValid, outData, outTag, inReady, e.pt, e.tag);
      end
      step();
    end
    nvec++; if (!stable) nmis++;
    outReady = 1;
    nvec++; if (inReady !== 1'b0 || outValid !== 1'b1) begin nmis++; $display("FAIL bp_hs: got ready %b valid %b expected 0 1", inReady, outValid); end
    step();
    outReady = 0;
    void'(sb.pop_front());
    nvec++; if (inReady !== 1'b1 || outValid !== 1'b0) begin nmis++; $display("FAIL bp_after: got ready %b valid %b expected 1 0", inReady, outValid); end
    c0 = cyc;
    e.pt = pb; e.tag = 8'h22;
    sb.push_back(e);
    step();
    inValid = 0;
    nvec++; if (inReady !== 1'b0) begin nmis++; $display("FAIL bp_accept: got ready %b expected 0", inReady); end
    recv(d, t, c1, ok);
    e = sb.pop_front();
    nvec++; if (!ok || d !== e.pt || t !== e.tag || c1 - c0 != 11) begin
      nmis++; $display("FAIL bp_second: got %h/%h lat %0d expected %h/%h lat 11", d, t, c1 - c0, e.pt, e.tag);
    end
  endtask

  task automatic test_back_to_back();
    int acc [3];
    int got;
    logic [127:0] pts [3];
    ks_sel = 0;
    for (int i = 0; i < 3; i++) pts[i] = rnd128();
    outReady = 1;
    got = 0;
    fork
      begin
        exp_t e;
        for (int i = 0; i < 3; i++) begin
          inData = enc(pts[i], 0, 10); inTag = 8'(i + 1); keyLen = 2'd0; inValid = 1;
          acc[i] = -1;
          for (int k = 0; k < 64; k++) begin
            if (inReady) begin
              acc[i] = cyc;
              e.pt = pts[i]; e.tag = 8'(i + 1);
              sb.push_back(e);
              step();
              break;
            end
            step();
          end
        end
        inValid = 0;
      end
      begin
        exp_t e;
        for (int k = 0; k < 120 && got < 3; k++) begin
          if (outValid) begin
            e = sb.pop_front();
            nvec++;
            if (outData !== e.pt || outTag !== e.tag) begin
              nmis++; $display("FAIL b2b_out%0d: got %h/%h expected %h/%h", got, outData, outTag, e.pt, e.tag);
            end
            got++;
          end
          step();
        end
      end
    join
    outReady = 0;
    nvec++; if (got != 3) begin nmis++; $display("FAIL b2b_count: got %0d expected 3", got); end
    nvec++; if (acc[1] - acc[0] != 12 || acc[2] - acc[1] != 12) begin
      nmis++; $display("FAIL b2b_spacing: got %0d %0d expected 12 12", acc[1] - acc[0], acc[2] - acc[1]);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [127:0] d;
    logic [TAG_W-1:0] t;
    int c0, c1;
    bit ok;
    exp_t e;
    ks_sel = 0;
    send(CT128, 8'h77, 2'd0, PT_FIPS, c0, ok);
    for (int k = 1; k < 5; k++) step();
    rst_n = 0;
    sb.delete();
    #1;
    nvec++; if (outValid !== 1'b0 || inReady !== 1'b0) begin nmis++; $display("FAIL mr_inrst: got valid %b ready %b expected 0 0", outValid, inReady); end
    step();
    rst_n = 1;
    #1;
    nvec++; if (outValid !== 1'b0 || inReady !== 1'b1) begin nmis++; $display("FAIL mr_release: got valid %b ready %b expected 0 1", outValid, inReady); end
    send(CT128, 8'h78, 2'd0, PT_FIPS, c0, ok);
    recv(d, t, c1, ok);
    e = sb.pop_front();
    nvec++; if (!ok || d !== e.pt || t !== e.tag || c1 - c0 != 11) begin
      nmis++; $display("FAIL mr_next: got %h/%h lat %0d expected %h/%h lat 11", d, t, c1 - c0, e.pt, e.tag);
    end
  endtask

`ifdef AES_DEC_ABORT_EN
  task automatic test_abort();
    logic [127:0] d;
    logic [TAG_W-1:0] t;
    int c0, c1;
    bit ok, quiet;
    exp_t e;
    ks_sel = 0;
    send(CT128, 8'h99, 2'd0, PT_FIPS, c0, ok);
    for (int k = 0; k < 20 && roundKeyIdx != 4'd4; k++) step();
    abort = 1;
    step();
    abort = 0;
    sb.delete();
    nvec++; if (inReady !== 1'b1 || outValid !== 1'b0 || outData !== '0 || outTag !== '0) begin
      nmis++; $display("FAIL ab_clear: got rdy %b valid %b %h %h expected 1 0 0 0", inReady, outValid, outData, outTag);
    end
    quiet = 1;
    for (int k = 0; k < 15; k++) begin
      if (outValid !== 1'b0) quiet = 0;
      step();
    end
    nvec++; if (!quiet) begin nmis++; $display("FAIL ab_quiet: got outValid 1 expected 0"); end
    abort = 1;
    send(CT128, 8'h9A, 2'd0, PT_FIPS, c0, ok);
    abort = 0;
    recv(d, t, c1, ok);
    e = sb.pop_front();
    nvec++; if (!ok || d !== e.pt || t !== e.tag || c1 - c0 != 11) begin
      nmis++; $display("FAIL ab_followup: got %h/%h lat %0d expected %h/%h lat 11", d, t, c1 - c0, e.pt, e.tag);
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: got no end expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    build_sbox();
    expand(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
    expand(1, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 6);
    expand(2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);
    test_reset();
    test_aes128();
    test_keylens();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
`ifdef AES_DEC_ABORT_EN
    test_abort();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
